// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter.
// State encoding and default handshake timeout.
package uart_arb_pkg;

  localparam int STATE_W    = 2;
  localparam int ACK_TO_DEF = 15;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set req bit after ptr, wrapping at NREQ-1.
// Purely combinational.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
)(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            valid,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] w_j;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    w_j   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      w_j = (w_j == IDXW'(NREQ - 1)) ? '0 : w_j + 1'b1;
      if (!valid && req[w_j]) begin
        valid = 1'b1;
        idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ producers.
// Optional UART_ARB_LOCK_EN adds a lock input for multi-byte bursts.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N      = 8,
  parameter int NREQ   = 4,
  parameter int IDXW   = 2,
  parameter int ACK_TO = ACK_TO_DEF
)(
  input  logic              clk,
  input  logic              nrst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NREQ-1:0]   lock,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic              tx_start,
  output logic [N-1:0]      tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic [IDXW-1:0]   owner,
  output logic              err_to
);

  localparam logic [7:0] TO_LAST = 8'(ACK_TO - 1);

  arb_state_t      r_state;
  logic [NREQ-1:0] r_gnt;
  logic            r_start;
  logic [N-1:0]    r_data;
  logic [IDXW-1:0] r_owner;
  logic [IDXW-1:0] r_ptr;
  logic [7:0]      r_cnt;
  logic            r_err;

  logic            w_rr_vld;
  logic [IDXW-1:0] w_rr_idx;
  logic            w_win_vld;
  logic [IDXW-1:0] w_win_idx;

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
    .req   (req),
    .ptr   (r_ptr),
    .valid (w_rr_vld),
    .idx   (w_rr_idx)
  );

`ifdef UART_ARB_LOCK_EN
  logic [NREQ-1:0] w_own_mask;
  logic            w_lk_vld;
  logic [IDXW-1:0] w_lk_idx;

  assign w_own_mask = NREQ'(1) << r_owner;

  // Searching from owner with only owner's bit visible yields owner itself.
  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_lk (
    .req   (req & lock & w_own_mask),
    .ptr   (r_owner),
    .valid (w_lk_vld),
    .idx   (w_lk_idx)
  );

  assign w_win_vld = w_lk_vld | w_rr_vld;
  assign w_win_idx = w_lk_vld ? w_lk_idx : w_rr_idx;
`else
  assign w_win_vld = w_rr_vld;
  assign w_win_idx = w_rr_idx;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_start <= 1'b0;
      r_data  <= '0;
      r_owner <= '0;
      r_ptr   <= IDXW'(NREQ - 1);
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_gnt <= '0;
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (tx_ready && w_win_vld) begin
            r_data  <= req_data[int'(w_win_idx)*N +: N];
            r_gnt   <= NREQ'(1) << w_win_idx;
            r_start <= 1'b1;
            r_owner <= w_win_idx;
            r_ptr   <= w_win_idx;
            r_cnt   <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!tx_ready) begin
            r_start <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else if (r_cnt == TO_LAST) begin
            // Transmitter never took the word: drop it.
            r_start <= 1'b0;
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (tx_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign tx_start = r_start;
  assign tx_data  = r_data;
  assign busy     = (r_state != S_IDLE);
  assign owner    = r_owner;
  assign err_to   = r_err;

endmodule
